// File: rtl/instr_packer_if.sv
// instr_packer_if: field-set input stream plus instruction-memory write port of the packer.
interface instr_packer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            fmt;
    logic [5:0]            opcode;
    logic [4:0]            wsel;
    logic [4:0]            rsel1;
    logic [4:0]            rsel2;
    logic [15:0]           imm;
    logic [25:0]           jimm;
    logic                  last;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    modport master (
        output in_valid, fmt, opcode, wsel, rsel1, rsel2, imm, jimm, last, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  in_valid, fmt, opcode, wsel, rsel1, rsel2, imm, jimm, last, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_packer.sv
// instr_packer: encodes R/I/J field sets into 32-bit words and writes them to consecutive memory addresses.
// Defining INSTR_PACKER_CHECKSUM_EN adds a running XOR checksum output of all completed writes.
module instr_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    instr_packer_if.slave         bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
`ifdef INSTR_PACKER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic [ADDR_WIDTH:0]   count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
    state_t state;
    logic [DATA_WIDTH-1:0] fifo [FIFO_DEPTH];
    logic [PW:0] wp, rp;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] word;
    logic empty, full, hs, push, pop, flush_done;
    assign empty = wp == rp;
    assign full = (wp ^ rp) == (PW+1)'(FIFO_DEPTH);
    assign bus.in_ready = state == LOAD && !full;
    assign hs = bus.in_valid && bus.in_ready;
    assign push = hs && bus.fmt != 2'd3;
    assign pop = !empty && bus.mem_ready;
    // FIFO drains this edge: either already empty or its only word is being written now
    assign flush_done = (wp - rp) == (PW+1)'(pop);
    assign bus.mem_we = !empty;
    assign bus.mem_addr = addr;
    assign bus.mem_wdata = empty ? '0 : fifo[rp[PW-1:0]];
    assign word = bus.fmt == 2'd0 ? {bus.opcode, bus.wsel, bus.rsel1, bus.rsel2, bus.imm[10:0]} :
                  bus.fmt == 2'd1 ? {bus.opcode, bus.wsel, bus.rsel1, bus.imm} :
                                    {bus.opcode, bus.jimm};
    always_ff @(posedge clk)
        if (push) fifo[wp[PW-1:0]] <= word;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wp <= '0;
            rp <= '0;
            addr <= ADDR_WIDTH'(BASE_ADDR);
            count <= '0;
            err <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
`ifdef INSTR_PACKER_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp <= rp + 1'b1;
                addr <= addr + 1'b1;
                count <= count + 1'b1;
                if (&addr) err <= 1'b1;
`ifdef INSTR_PACKER_CHECKSUM_EN
                checksum <= checksum ^ bus.mem_wdata;
`endif
            end
            if (hs && bus.fmt == 2'd3) err <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    state <= LOAD;
                    busy <= 1'b1;
                    addr <= ADDR_WIDTH'(BASE_ADDR);
                    count <= '0;
                    err <= 1'b0;
`ifdef INSTR_PACKER_CHECKSUM_EN
                    checksum <= '0;
`endif
                end
                LOAD: if (hs && bus.last) state <= FLUSH;
                FLUSH: if (flush_done) begin
                    state <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_packer.sv
// tb_instr_packer: table vectors, hand-written corner sequences and randomized sessions
// checked against a queue-based model of the packer's write stream.
module tb_instr_packer;
    typedef struct {
        logic [1:0]  f;
        logic [5:0]  op;
        logic [4:0]  ws, r1, r2;
        logic [15:0] im;
        logic [25:0] ji;
        logic [31:0] word;
    } vec_t;

    logic clk = 0, rst = 1, start = 0, sel = 0, in_valid = 0, last = 0;
    logic mr_fixed = 0, rnd_ready = 0, rr = 0, mem_ready;
    logic [1:0] fmt = 0;
    logic [5:0] opcode = 0;
    logic [4:0] wsel = 0, rsel1 = 0, rsel2 = 0;
    logic [15:0] imm = 0;
    logic [25:0] jimm = 0;
    int n_checks = 0, n_err = 0;

    always #5 clk = ~clk;
    always begin
        @(posedge clk);
        #1 rr = 1'($urandom_range(0, 1));
    end
    assign mem_ready = rnd_ready ? rr : mr_fixed;

    instr_packer_if #(.ADDR_WIDTH(8)) ia ();
    instr_packer_if #(.ADDR_WIDTH(2)) iw ();
    assign ia.in_valid = in_valid && !sel;
    assign iw.in_valid = in_valid && sel;
    assign ia.fmt = fmt;       assign iw.fmt = fmt;
    assign ia.opcode = opcode; assign iw.opcode = opcode;
    assign ia.wsel = wsel;     assign iw.wsel = wsel;
    assign ia.rsel1 = rsel1;   assign iw.rsel1 = rsel1;
    assign ia.rsel2 = rsel2;   assign iw.rsel2 = rsel2;
    assign ia.imm = imm;       assign iw.imm = imm;
    assign ia.jimm = jimm;     assign iw.jimm = jimm;
    assign ia.last = last;     assign iw.last = last;
    assign ia.mem_ready = mem_ready;
    assign iw.mem_ready = mem_ready;

    logic busy_a, done_a, err_a, busy_w, done_w, err_w;
    logic [8:0] count_a;
    logic [2:0] count_w;
`ifdef INSTR_PACKER_CHECKSUM_EN
    logic [31:0] ck_a, ck_w, ck_v;
    assign ck_v = sel ? ck_w : ck_a;
`endif

    instr_packer #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start && !sel), .bus(ia),
        .busy(busy_a), .done(done_a), .err(err_a),
`ifdef INSTR_PACKER_CHECKSUM_EN
        .checksum(ck_a),
`endif
        .count(count_a)
    );
    instr_packer #(.ADDR_WIDTH(2)) dut_w (
        .clk(clk), .rst(rst), .start(start && sel), .bus(iw),
        .busy(busy_w), .done(done_w), .err(err_w),
`ifdef INSTR_PACKER_CHECKSUM_EN
        .checksum(ck_w),
`endif
        .count(count_w)
    );

    logic rdy, we, busy_v, done_v, err_v;
    logic [7:0] addr_v;
    logic [31:0] wdata_v;
    logic [8:0] count_v;
    assign rdy = sel ? iw.in_ready : ia.in_ready;
    assign we = sel ? iw.mem_we : ia.mem_we;
    assign busy_v = sel ? busy_w : busy_a;
    assign done_v = sel ? done_w : done_a;
    assign err_v = sel ? err_w : err_a;
    assign addr_v = sel ? {6'd0, iw.mem_addr} : ia.mem_addr;
    assign wdata_v = sel ? iw.mem_wdata : ia.mem_wdata;
    assign count_v = sel ? {6'd0, count_w} : count_a;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] enc(input logic [1:0] f, input logic [5:0] op, input logic [4:0] ws,
                                        input logic [4:0] r1, input logic [4:0] r2, input logic [15:0] im,
                                        input logic [25:0] ji);
        case (f)
            2'd0: return (32'(op) << 26) | (32'(ws) << 21) | (32'(r1) << 16) | (32'(r2) << 11) | 32'(im & 16'h07FF);
            2'd1: return (32'(op) << 26) | (32'(ws) << 21) | (32'(r1) << 16) | 32'(im);
            default: return (32'(op) << 26) | 32'(ji);
        endcase
    endfunction

    // Reference model: phase 0 idle, 1 load, 2 flush, 3 done; exp_q holds words awaiting memory.
    logic [31:0] exp_q[$];
    logic [31:0] wlog[$];
    int alog[$];
    int phase = 0, exp_addr = 0, m_count = 0, amask = 255;
    logic m_err = 0;
    logic [31:0] m_ck = 0;

    always @(negedge clk) begin
        if (rst) begin
            phase = 0;
            exp_q.delete();
            exp_addr = 0;
            m_count = 0;
            m_err = 0;
            m_ck = 0;
        end else begin
            chk("busy", 32'(busy_v), 32'(phase == 1 || phase == 2));
            chk("done", 32'(done_v), 32'(phase == 3));
            chk("in_ready", 32'(rdy), 32'(phase == 1 && exp_q.size() < 4));
            chk("mem_we", 32'(we), 32'(exp_q.size() != 0));
            chk("mem_addr", 32'(addr_v), 32'(exp_addr));
            chk("count", 32'(count_v), 32'(m_count));
            chk("err", 32'(err_v), 32'(m_err));
`ifdef INSTR_PACKER_CHECKSUM_EN
            chk("checksum", ck_v, m_ck);
`endif
            if (!we) chk("wdata_idle", wdata_v, 32'd0);
            if (we && mem_ready && exp_q.size() != 0) begin
                chk("wdata", wdata_v, exp_q.pop_front());
                wlog.push_back(wdata_v);
                alog.push_back(int'(addr_v));
                if (exp_addr == amask) m_err = 1;
                exp_addr = (exp_addr + 1) & amask;
                m_count++;
                m_ck ^= wdata_v;
            end
            if (phase == 1 && in_valid && rdy) begin
                if (fmt == 2'd3) m_err = 1;
                else exp_q.push_back(enc(fmt, opcode, wsel, rsel1, rsel2, imm, jimm));
                if (last) phase = 2;
            end else if (phase == 2 && exp_q.size() == 0) phase = 3;
            else if (phase == 3) phase = 0;
            else if (phase == 0 && start) begin
                phase = 1;
                exp_addr = 0;
                m_count = 0;
                m_err = 0;
                m_ck = 0;
            end
        end
    end

    task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] ws, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [15:0] im, input logic [25:0] ji, input logic l);
        int n = 0;
        fmt = f; opcode = op; wsel = ws; rsel1 = r1; rsel2 = r2; imm = im; jimm = ji; last = l;
        in_valid = 1;
        forever begin
            @(negedge clk);
            if (rdy) break;
            if (++n > 300) begin
                chk("send_timeout_ready", 32'(rdy), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 0;
        last = 0;
    endtask

    task automatic send_rand(input logic [1:0] f, input logic l);
        send(f, 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom), l);
    endtask

    task automatic begin_session();
        wlog.delete();
        alog.delete();
        start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        forever begin
            @(negedge clk);
            if (done_v) break;
            if (++n > 500) begin
                chk("done_timeout", 32'(done_v), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
    endtask

    vec_t tbl[6];
    int k, nv;
    logic [1:0] rf;

    initial begin
        tbl[0] = '{2'd0, 6'h00, 5'd3, 5'd1, 5'd2, 16'h0020, 26'h0, 32'h00611020};
        tbl[1] = '{2'd1, 6'h08, 5'd5, 5'd4, 5'd0, 16'hFFFC, 26'h0, 32'h20A4FFFC};
        tbl[2] = '{2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h100, 32'h08000100};
        tbl[3] = '{2'd0, 6'h3F, 5'd31, 5'd0, 5'd31, 16'hFFFF, 26'h0, 32'hFFE0FFFF};
        tbl[4] = '{2'd1, 6'h23, 5'd0, 5'd31, 5'd7, 16'h1234, 26'h0, 32'h8C1F1234};
        tbl[5] = '{2'd2, 6'h03, 5'd9, 5'd9, 5'd9, 16'hAAAA, 26'h3FFFFFF, 32'h0FFFFFFF};
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_mem_we", 32'(we), 32'd0);
        chk("rst_in_ready", 32'(rdy), 32'd0);
        chk("rst_count", 32'(count_v), 32'd0);
        chk("rst_wdata", wdata_v, 32'd0);
        @(posedge clk);
        #1 mr_fixed = 1;
        for (int s = 0; s < 2; s++) begin
            begin_session();
            for (int i = 0; i < 3; i++)
                send(tbl[3*s+i].f, tbl[3*s+i].op, tbl[3*s+i].ws, tbl[3*s+i].r1, tbl[3*s+i].r2,
                     tbl[3*s+i].im, tbl[3*s+i].ji, i == 2);
            wait_done();
            chk("tbl_count", 32'(count_v), 32'd3);
            chk("tbl_err", 32'(err_v), 32'd0);
            chk("tbl_nwords", 32'(wlog.size()), 32'd3);
            for (int i = 0; i < 3 && i < wlog.size(); i++) begin
                chk("tbl_word", wlog[i], tbl[3*s+i].word);
                chk("tbl_addr", 32'(alog[i]), 32'(i));
            end
`ifdef INSTR_PACKER_CHECKSUM_EN
            if (s == 0) chk("tbl_checksum", ck_v, 32'h28C5EEDC);
`endif
        end
        mr_fixed = 0;
        begin_session();
        for (int i = 0; i < 4; i++) send_rand(2'($urandom_range(0, 2)), 1'b0);
        @(negedge clk);
        chk("bp_ready", 32'(rdy), 32'd0);
        chk("bp_we", 32'(we), 32'd1);
        chk("bp_addr", 32'(addr_v), 32'd0);
        @(posedge clk);
        #1 mr_fixed = 1;
        send_rand(2'd1, 1'b1);
        wait_done();
        chk("bp_count", 32'(count_v), 32'd5);
        chk("bp_nwords", 32'(wlog.size()), 32'd5);
        for (int i = 0; i < 5 && i < alog.size(); i++) chk("bp_waddr", 32'(alog[i]), 32'(i));
        begin_session();
        send_rand(2'd0, 1'b0);
        send_rand(2'd3, 1'b1);
        wait_done();
        chk("inv_count", 32'(count_v), 32'd1);
        chk("inv_err", 32'(err_v), 32'd1);
        chk("inv_nwords", 32'(wlog.size()), 32'd1);
        mr_fixed = 0;
        begin_session();
        send_rand(2'd0, 1'b0);
        send_rand(2'd1, 1'b0);
        pulse_rst();
        @(negedge clk);
        chk("rm_we", 32'(we), 32'd0);
        chk("rm_busy", 32'(busy_v), 32'd0);
        chk("rm_count", 32'(count_v), 32'd0);
        chk("rm_ready", 32'(rdy), 32'd0);
        chk("rm_wdata", wdata_v, 32'd0);
        @(posedge clk);
        #1 mr_fixed = 1;
        begin_session();
        send_rand(2'd2, 1'b1);
        wait_done();
        chk("rm_nwords", 32'(wlog.size()), 32'd1);
        if (alog.size() > 0) chk("rm_addr0", 32'(alog[0]), 32'd0);
        rnd_ready = 1;
        for (int s = 0; s < 25; s++) begin
            k = $urandom_range(1, 10);
            nv = 0;
            begin_session();
            for (int i = 0; i < k; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                if (i == k - 1 && $urandom_range(0, 1) == 1) begin
                    start = 1;
                    @(posedge clk);
                    #1 start = 0;
                end
                rf = ($urandom_range(0, 6) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                if (rf != 2'd3) nv++;
                send_rand(rf, i == k - 1);
            end
            wait_done();
            chk("rnd_count", 32'(count_v), 32'(nv));
        end
        rnd_ready = 0;
        mr_fixed = 1;
        sel = 1;
        amask = 3;
        pulse_rst();
        begin_session();
        for (int i = 0; i < 5; i++) send_rand(2'($urandom_range(0, 2)), i == 4);
        wait_done();
        chk("wrap_count", 32'(count_v), 32'd5);
        chk("wrap_err", 32'(err_v), 32'd1);
        chk("wrap_nwords", 32'(alog.size()), 32'd5);
        if (alog.size() > 4) chk("wrap_addr4", 32'(alog[4]), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/instr_packer.md
# instr_packer

Instruction packer and loader: accepts instructions as separate fields over a valid/ready stream and encodes each one into a 32-bit word. Field placement is identical to the instruction-register decode: opcode [31:26], WriteSelect [25:21], ReadSelect1 [20:16], ReadSelect2 [15:11], Imm [15:0], Jump_Imm [25:0]. Encoded words are buffered in a small FIFO and written into instruction memory at consecutive addresses. The block is the writer side of the instruction path and is used by the test harness and boot logic to fill instruction memory before the multicycle core runs.

## Interface
- DATA_WIDTH, 32, instruction word width; only 32 is supported.
- ADDR_WIDTH, 8, instruction memory word-address width.
- FIFO_DEPTH, 4, encoded-word buffer depth; must be a power of 2 and ≥ 2.
- BASE_ADDR, 0, first write address of every session.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begins a load session; honoured only in IDLE.
- in_valid  in  1  field set is valid.
- in_ready  out  1  packer accepts the field set.
- fmt  in  2  format: 0 = R, 1 = I, 2 = J, 3 = invalid.
- opcode  in  6  opcode field.
- wsel  in  5  WriteSelect field.
- rsel1  in  5  ReadSelect1 field.
- rsel2  in  5  ReadSelect2 field.
- imm  in  16  immediate field.
- jimm  in  26  jump immediate field.
- last  in  1  marks the final instruction of the session.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_WIDTH  write word address.
- mem_wdata  out  DATA_WIDTH  encoded word.
- mem_ready  in  1  memory accepts the write this cycle.
- busy  out  1  high in LOAD and FLUSH.
- done  out  1  one-cycle pulse at the end of a session.
- err  out  1  sticky error flag; cleared by start.
- count  out  ADDR_WIDTH+1  number of words written this session.

## Operation
- Encoding:
  - R: {opcode, wsel, rsel1, rsel2, imm[10:0]}.
  - I: {opcode, wsel, rsel1, imm}.
  - J: {opcode, jimm}.
- FSM states: IDLE, LOAD, FLUSH, DONE.
  - IDLE: in_ready=0. On start: go to LOAD; mem_addr←BASE_ADDR; count←0; err←0.
  - LOAD: in_ready = !fifo_full. Handshake = in_valid & in_ready. A handshake with fmt≠3 pushes the encoded word.
  - LOAD → FLUSH: on a handshake with last=1.
  - FLUSH: in_ready=0. Go to DONE when the FIFO is empty.
  - DONE: done=1 for one cycle, then IDLE.
- Invalid format: handshake with fmt=3 completes normally (consumed), nothing is pushed, err←1. The last flag on such a handshake is still honoured.
- Write side: mem_we = !fifo_empty, in every state. mem_wdata = FIFO head, or 0 when the FIFO is empty.
  - A write completes on mem_we & mem_ready: pop the FIFO, mem_addr←mem_addr+1, count←count+1.
  - mem_addr, mem_wdata and mem_we stay stable until mem_ready.
- Full FIFO: no push bypass; a same-cycle pop does not raise in_ready that cycle. Push and pop in the same cycle on a non-full FIFO are both performed.
- Address wrap: mem_addr wraps modulo 2^ADDR_WIDTH. A write completing at address 2^ADDR_WIDTH−1 sets err.
- start outside IDLE is ignored.
- Reset mid-session: FIFO emptied and state→IDLE. All outputs return to their reset values: in_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, busy 0, done 0, err 0, count 0, checksum 0.

## Timing
- start at edge N → busy=1 and in_ready=1 (FIFO empty) in cycle N+1.
- Handshake at edge N → mem_we=1 with that word in cycle N+1 at the earliest.
- Single-word throughput: one word per cycle while mem_ready is held high.
- Last word written at edge N → state is DONE with done=1 in cycle N+1 (FLUSH empty check costs one cycle after the pop). State is IDLE in cycle N+2.
- done and busy are never high together.

## Configuration
- INSTR_PACKER_CHECKSUM_EN defined:
  - Adds output checksum [DATA_WIDTH-1:0].
  - checksum is the running XOR of every completed memory write this session.
  - Cleared by start and by rst; stable after done.
- INSTR_PACKER_CHECKSUM_EN undefined: the checksum port and its logic are absent; all other behaviour is identical.

## Test plan
- Encoding, mem_ready=1. Push three instructions, the last with last=1:
  - R: opcode 0, wsel 3, rsel1 1, rsel2 2, imm 0x020 → 0x00611020 written at addr 0.
  - I: opcode 0x08, wsel 5, rsel1 4, imm 0xFFFC → 0x20A4FFFC at addr 1.
  - J: opcode 0x02, jimm 0x100 → 0x08000100 at addr 2.
  - Expect count=3, done pulse, err=0, checksum=0x28C5EEDC when enabled.
- Backpressure: mem_ready=0, push 5 valid words → in_ready=0 after the 4th handshake with the 5th held. Raise mem_ready → words 1–5 written in order at addr 0–4.
- Invalid format: fmt=3 with last=1 as the 2nd of 2 instructions → only the 1st word is written, count=1, err=1, done pulses.
- Wrap: ADDR_WIDTH=2, BASE_ADDR=0, 5 words → 5th word written at addr 0, err=1, count=5.
- Reset mid-session: rst asserted with 2 words in the FIFO and mem_ready=0 → next cycle mem_we=0, busy=0, count=0. Then start plus 1 word → write at BASE_ADDR.
